// File: rtl/prog_rom_if.sv
// Program-load byte stream plus CPU instruction-fetch bus for prog_rom.
interface prog_rom_if;
    logic       load_start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [3:0] addr;
    logic [3:0] opecode;
    logic [3:0] imm;
    logic       cpu_hold;
    logic [4:0] load_count;
    logic [7:0] checksum;
    logic       loaded;

    modport master (
        output load_start, in_valid, in_data, addr,
        input  in_ready, opecode, imm, cpu_hold, load_count, checksum, loaded
    );

    modport slave (
        input  load_start, in_valid, in_data, addr,
        output in_ready, opecode, imm, cpu_hold, load_count, checksum, loaded
    );
endinterface

// File: rtl/prog_rom.sv
// Loadable 16x8 program ROM; combinational read, one-cycle write-to-read visibility.
// Accepts one byte per cycle only in LOAD (in_ready), holds the CPU in reset until a full program is resident.
module prog_rom #(
    parameter int DEPTH = 16
) (
    input  logic      clk,
    input  logic      rst,
    prog_rom_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;

    typedef struct packed {
        logic [3:0] opecode;
        logic [3:0] imm;
    } instr_t;

    state_t     state, state_nxt;
    instr_t     mem [DEPTH];
    logic [3:0] wptr;
    logic [4:0] load_count;
    logic [7:0] checksum;
    logic       accept;

    // load_start wins over a byte handshaken in the same cycle
    assign accept = bus.in_valid && (state == LOAD) && !bus.load_start;

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (bus.load_start) state_nxt = LOAD;
            LOAD:    if (!bus.load_start && accept && wptr == 4'(DEPTH - 1))
                         state_nxt = RUN;
            RUN:     if (bus.load_start) state_nxt = LOAD;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        bus.cpu_hold = (state != RUN);
        bus.in_ready = (state == LOAD);
        bus.loaded   = (state == RUN);
        bus.opecode  = 4'h0;
        bus.imm      = 4'h0;
        // Outside RUN the CPU sees ADD A,0, which has no side effect
        if (state == RUN) begin
            bus.opecode = mem[bus.addr].opecode;
            bus.imm     = mem[bus.addr].imm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= '0;
            load_count <= '0;
            checksum   <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (bus.load_start) begin
            wptr       <= '0;
            load_count <= '0;
            checksum   <= '0;
        end else if (accept) begin
            mem[wptr]  <= bus.in_data;
            wptr       <= wptr + 4'd1;
            load_count <= load_count + 5'd1;
            checksum   <= checksum + bus.in_data;
        end
    end

    assign bus.load_count = load_count;
    assign bus.checksum   = checksum;
endmodule

// File: tb/tb_prog_rom.sv
module tb_prog_rom;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    prog_rom_if bus();

    prog_rom #(.DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] addr;
        logic [3:0] exp_op;
        logic [3:0] exp_imm;
    } rd_vec_t;

    rd_vec_t    tbl [16];
    logic [7:0] prog_a [16];
    logic [7:0] prog_b [16];
    logic [7:0] prog_c [16];
    logic [7:0] prog_d [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] sum8(input logic [7:0] d [16]);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < 16; i++) s = s + d[i];
        return s;
    endfunction

    task automatic pulse_start();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        chk("start_hold", bus.cpu_hold, 1);
        chk("start_ready", bus.in_ready, 1);
        chk("start_count", bus.load_count, 0);
        chk("start_csum", bus.checksum, 0);
    endtask

    // Streams the first n bytes of d; bub inserts an idle cycle before each byte
    task automatic feed(input logic [7:0] d [16], input int n, input bit bub);
        for (int i = 0; i < n; i++) begin
            if (bub) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'hEE;
                tick();
            end
            bus.in_valid = 1'b1;
            bus.in_data  = d[i];
            if (i == 8) begin
                chk("load_read_op", bus.opecode, 0);
                chk("load_read_imm", bus.imm, 0);
            end
            if (i == 15) chk("hold_before_last", bus.cpu_hold, 1);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
    endtask

    task automatic check_run(input logic [7:0] d [16]);
        chk("run_hold", bus.cpu_hold, 0);
        chk("run_loaded", bus.loaded, 1);
        chk("run_ready", bus.in_ready, 0);
        chk("run_count", bus.load_count, 16);
        chk("run_csum", bus.checksum, {24'h0, sum8(d)});
    endtask

    task automatic sweep(input logic [7:0] d [16]);
        for (int a = 0; a < 16; a++) begin
            bus.addr = 4'(a);
            #1;
            chk("sweep", {bus.opecode, bus.imm}, {24'h0, d[a]});
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.load_start = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = 8'h00;
        bus.addr       = 4'h0;

        for (int i = 0; i < 16; i++) begin
            tbl[i]    = '{4'(15 - i), 4'h3, 4'(15 - i)};
            prog_a[i] = 8'h30 + 8'(i);
            prog_b[i] = 8'hB5;
            prog_c[i] = 8'(i * 37 + 5);
            prog_d[i] = 8'h60 + 8'(i * 3);
        end

        tick();
        tick();
        rst = 1'b0;
        chk("rst_hold", bus.cpu_hold, 1);
        chk("rst_ready", bus.in_ready, 0);
        chk("rst_loaded", bus.loaded, 0);
        chk("rst_count", bus.load_count, 0);
        chk("rst_csum", bus.checksum, 0);
        chk("rst_op", bus.opecode, 0);
        chk("rst_imm", bus.imm, 0);

        // Stray bytes in EMPTY are ignored
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        for (int i = 0; i < 5; i++) tick();
        chk("idle_count", bus.load_count, 0);
        chk("idle_csum", bus.checksum, 0);
        chk("idle_ready", bus.in_ready, 0);
        chk("idle_hold", bus.cpu_hold, 1);
        bus.in_valid = 1'b0;

        // Back-to-back load of 0x30..0x3F, checked through the table
        pulse_start();
        feed(prog_a, 16, 1'b0);
        check_run(prog_a);
        chk("a_csum_const", bus.checksum, 8'h78);
        for (int i = 0; i < 16; i++) begin
            bus.addr = tbl[i].addr;
            #1;
            chk("tbl_op", bus.opecode, tbl[i].exp_op);
            chk("tbl_imm", bus.imm, tbl[i].exp_imm);
        end

        // Bytes offered in RUN must not be written or counted
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        tick();
        tick();
        bus.in_valid = 1'b0;
        chk("run_ign_count", bus.load_count, 16);
        sweep(prog_a);

        // Reload from RUN with all 0xB5
        bus.load_start = 1'b1;
        chk("reload_hold_pre", bus.cpu_hold, 0);
        tick();
        bus.load_start = 1'b0;
        chk("reload_hold", bus.cpu_hold, 1);
        chk("reload_loaded", bus.loaded, 0);
        chk("reload_count", bus.load_count, 0);
        feed(prog_b, 16, 1'b0);
        check_run(prog_b);
        chk("b_csum_const", bus.checksum, 8'h50);
        sweep(prog_b);

        // Load with bubbles between every byte
        pulse_start();
        feed(prog_c, 16, 1'b1);
        check_run(prog_c);
        sweep(prog_c);

        // Restart mid-load: 0x99 offered with load_start is discarded
        pulse_start();
        feed(prog_a, 7, 1'b0);
        chk("mid_count7", bus.load_count, 7);
        bus.load_start = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_data    = 8'h99;
        tick();
        bus.load_start = 1'b0;
        bus.in_valid   = 1'b0;
        chk("restart_count", bus.load_count, 0);
        chk("restart_csum", bus.checksum, 0);
        chk("restart_hold", bus.cpu_hold, 1);
        feed(prog_d, 16, 1'b0);
        check_run(prog_d);
        sweep(prog_d);

        // Reset mid-load wipes memory and returns to EMPTY
        pulse_start();
        feed(prog_c, 9, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_hold", bus.cpu_hold, 1);
        chk("mrst_ready", bus.in_ready, 0);
        chk("mrst_loaded", bus.loaded, 0);
        chk("mrst_count", bus.load_count, 0);
        chk("mrst_csum", bus.checksum, 0);
        for (int i = 0; i < 16; i++) chk("mrst_mem", {24'h0, dut.mem[i]}, 0);
        tick();
        chk("mrst_stay_empty", bus.in_ready, 0);

        pulse_start();
        feed(prog_a, 16, 1'b0);
        check_run(prog_a);
        sweep(prog_a);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
